// File: rtl/aes_key_expander_if.sv
// aes_key_expander_if: connects the AES round-key generator to the core top.
// The master side is the core top (it starts expansion, requests round keys
// and owns the shared S-box). The slave side is aes_key_expander.
interface aes_key_expander_if;
    logic         init;
    logic [255:0] key;
    logic         keylen;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic [31:0]  sboxw;
    logic [31:0]  new_sboxw;
    logic         ready;

    modport master (
        output init, key, keylen, round, new_sboxw,
        input  round_key, sboxw, ready
    );

    modport slave (
        input  init, key, keylen, round, new_sboxw,
        output round_key, sboxw, ready
    );
endinterface

// File: rtl/aes_key_expander.sv
// aes_key_expander: expands a 128-bit (or, with AES_KEY_EXP_256_EN defined,
// a 256-bit) cipher key into the AES round-key schedule, one round key per
// cycle, and serves round_key[round] combinationally afterwards.
// The S-box is shared with the encipher block: this block presents a word on
// sboxw and receives its substitution on new_sboxw in the same cycle.
// Without AES_KEY_EXP_256_EN the block is AES-128 only: keylen and key[127:0]
// are ignored and the key memory holds 11 entries.
module aes_key_expander (
    input  logic              clk,
    input  logic              reset,
    aes_key_expander_if.slave bus
);

`ifdef AES_KEY_EXP_256_EN
    localparam int NUM_RK = 15;
`else
    localparam int NUM_RK = 11;
`endif

    typedef enum logic {
        IDLE,
        GENERATE
    } state_t;

    state_t       state;
    state_t       state_next;
    logic         ready_q;
    logic         ready_next;
    logic [3:0]   r;
    logic [3:0]   r_next;
    logic [7:0]   rcon;
    logic [7:0]   rcon_next;
    logic         len256;
    logic         len256_next;
    logic         load;
    logic         gen_we;
    logic         keylen_eff;

    logic [127:0] rk [NUM_RK];
    logic [127:0] p;
    logic [127:0] pp;
    logic [127:0] rk_back2;
    logic [127:0] new_rk;
    logic         rotate;
    logic         last_step;
    logic [31:0]  w3;
    logic [31:0]  sub_in;
    logic [31:0]  t;
    logic [31:0]  k0;
    logic [31:0]  k1;
    logic [31:0]  k2;
    logic [31:0]  k3;

`ifdef AES_KEY_EXP_256_EN
    assign keylen_eff = bus.keylen;
`else
    // AES-128 only build: the key length select and the low key half are dead.
    logic unused_inputs;
    assign unused_inputs = ^{bus.keylen, bus.key[127:0]};
    assign keylen_eff    = 1'b0;
`endif

    // GF(2^8) multiply by x, used to step the round constant.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    // Fetch the previous one/two round keys that feed the current step.
    always_comb begin
        p        = '0;
        rk_back2 = '0;
        for (int i = 0; i < NUM_RK; i++) begin
            if (r - 4'd1 == 4'(i)) p = rk[i];
            if (r - 4'd2 == 4'(i)) rk_back2 = rk[i];
        end
        pp = len256 ? rk_back2 : p;
    end

    // Key-schedule word arithmetic for the round key written this cycle.
    always_comb begin
        // AES-256 alternates: even steps rotate and add rcon, odd steps only substitute.
        rotate    = !len256 || !r[0];
        w3        = p[31:0];
        sub_in    = rotate ? {w3[23:0], w3[31:24]} : w3;
        bus.sboxw = (state == GENERATE) ? sub_in : 32'h0;
        t         = rotate ? (bus.new_sboxw ^ {rcon, 24'h0}) : bus.new_sboxw;
        k0        = pp[127:96] ^ t;
        k1        = pp[95:64]  ^ k0;
        k2        = pp[63:32]  ^ k1;
        k3        = pp[31:0]   ^ k2;
        new_rk    = {k0, k1, k2, k3};
        last_step = len256 ? (r == 4'd14) : (r == 4'd10);
    end

    // Round-key read port: pure mux, unpopulated indices read as zero.
    always_comb begin
        bus.round_key = '0;
        for (int i = 0; i < NUM_RK; i++) begin
            if (bus.round == 4'(i)) bus.round_key = rk[i];
        end
    end

    assign bus.ready = ready_q;

    // FSM next-state and control decode.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        state_next  = state;
        ready_next  = ready_q;
        r_next      = r;
        rcon_next   = rcon;
        len256_next = len256;
        load        = 1'b0;
        gen_we      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.init) begin
                    load        = 1'b1;
                    len256_next = keylen_eff;
                    rcon_next   = 8'h01;
                    r_next      = keylen_eff ? 4'd2 : 4'd1;
                    ready_next  = 1'b0;
                    state_next  = GENERATE;
                end
            end
            GENERATE: begin
                gen_we = 1'b1;
                r_next = r + 4'd1;
                if (rotate) rcon_next = xtime(rcon);
                if (last_step) begin
                    ready_next = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and control registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            r       <= 4'd0;
            rcon    <= 8'h01;
            len256  <= 1'b0;
        end else begin
            state   <= state_next;
            ready_q <= ready_next;
            r       <= r_next;
            rcon    <= rcon_next;
            len256  <= len256_next;
        end
    end

    // Key memory: loaded from the cipher key on init, then one entry per step.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the key memory is deliberately reset; round_key must read
            // zero after reset, so this storage is built from flops, not RAM.
            for (int i = 0; i < NUM_RK; i++) rk[i] <= '0;
        end else if (load) begin
            rk[0] <= bus.key[255:128];
            if (keylen_eff) rk[1] <= bus.key[127:0];
        end else if (gen_we) begin
            rk[r] <= new_rk;
        end
    end

endmodule
